// File: rtl/xu_gpr_mp.sv
// xu_gpr_mp: multi-port GPR array with byte parity, clear-on-reset sequencer,
// write-conflict detection, deferred third-source read and background scrubber.
module xu_gpr_mp #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 144,
  parameter int AW    = 8,
  parameter int RP    = 4,
  parameter int WP    = 4
) (
  input  logic                          nclk,
  input  logic                          rst,
  input  logic [RP-1:0]                 r_e,
  input  logic [RP*AW-1:0]              r_a,
  output logic [RP*WIDTH-1:0]           r_d,
  output logic [RP-1:0]                 r_pe,
  input  logic                          sx_e,
  input  logic [AW-1:0]                 sx_a,
  input  logic                          sx_sel,
  output logic                          sx_steal,
  input  logic [WP-1:0]                 w_e,
  input  logic [WP*AW-1:0]              w_a,
  input  logic [WP*(WIDTH+WIDTH/8)-1:0] w_d,
  output logic                          w_conflict,
  output logic                          init_busy,
  input  logic                          scrub_en,
  output logic                          scrub_err,
  output logic                          scrub_err_vld,
  output logic [AW-1:0]                 scrub_err_addr,
  input  logic                          scrub_err_clr,
  output logic                          scrub_wrap
);
  localparam int NB = WIDTH / 8;
  localparam int EW = WIDTH + NB;
  localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;
  state_t state, state_nxt;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] init_ptr;
  logic          run;
  logic          sx_e_q;
  logic [AW-1:0] sx_a_q;
  logic [AW-1:0] scrub_ptr;
  logic [AW-1:0] scrub_addr_q;
  logic          scrub_bad_q;
  logic          steal;
  logic          scrub_go;
  logic          conflict;
  logic [WP-1:0] w_ok;
  logic [RP-1:0] rd_en;
  logic [AW-1:0] rd_addr [RP];
  logic [EW-1:0] rd_val  [RP];
  logic [EW-1:0] scrub_val;

  function automatic logic par_bad(input logic [EW-1:0] e);
    logic bad;
    bad = 1'b0;
    for (int unsigned b = 0; b < NB; b++)
      bad |= ((^e[b*8 +: 8]) != e[WIDTH+b]);
    return bad;
  endfunction

  // Array lookup with write-before-read bypass; highest-numbered writer wins.
  function automatic logic [EW-1:0] lookup(input logic [AW-1:0] a);
    logic [EW-1:0] v;
    v = '0;
    if ({1'b0, a} < DEPTH_X) begin
      v = mem[a];
      for (int unsigned p = 0; p < WP; p++)
        if (w_ok[p] && (w_a[p*AW +: AW] == a)) v = w_d[p*EW +: EW];
    end
    return v;
  endfunction

  assign run       = (state == ST_RUN);
  assign init_busy = ~run;
  assign sx_steal  = steal;
  assign scrub_err = scrub_bad_q;
  assign scrub_wrap = scrub_go & (scrub_ptr == LAST);

  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && init_ptr == LAST) state_nxt = ST_RUN;
  end

  always_comb begin
    w_ok     = '0;
    conflict = 1'b0;
    for (int unsigned p = 0; p < WP; p++)
      w_ok[p] = run & w_e[p] & ({1'b0, w_a[p*AW +: AW]} < DEPTH_X);
    for (int unsigned i = 0; i < WP; i++)
      for (int unsigned j = i + 1; j < WP; j++)
        if (run && w_e[i] && w_e[j] && (w_a[i*AW +: AW] == w_a[j*AW +: AW]))
          conflict = 1'b1;
  end

  // A steal replaces port 0's request; the scrubber only fills leftover port-0 slots.
  always_comb begin
    steal = run & sx_e_q & sx_sel;
    for (int unsigned k = 0; k < RP; k++) begin
      rd_addr[k] = r_a[k*AW +: AW];
      rd_en[k]   = run & r_e[k];
    end
    if (steal) begin
      rd_addr[0] = sx_a_q;
      rd_en[0]   = 1'b1;
    end
    scrub_go = run & scrub_en & ~rd_en[0];
    for (int unsigned k = 0; k < RP; k++) rd_val[k] = lookup(rd_addr[k]);
    scrub_val = lookup(scrub_ptr);
  end

  always_ff @(posedge nclk) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nxt;
  end

  always_ff @(posedge nclk) begin
    if (!rst) begin
      if (!run) mem[init_ptr] <= '0;
      else
        for (int unsigned p = 0; p < WP; p++)
          if (w_ok[p]) mem[w_a[p*AW +: AW]] <= w_d[p*EW +: EW];
    end
  end

  always_ff @(posedge nclk) begin
    if (rst) begin
      init_ptr       <= '0;
      r_d            <= '0;
      r_pe           <= '0;
      sx_e_q         <= 1'b0;
      sx_a_q         <= '0;
      w_conflict     <= 1'b0;
      scrub_ptr      <= '0;
      scrub_addr_q   <= '0;
      scrub_bad_q    <= 1'b0;
      scrub_err_vld  <= 1'b0;
      scrub_err_addr <= '0;
    end else begin
      if (!run) init_ptr <= init_ptr + 1'b1;
      sx_e_q     <= run & sx_e;
      sx_a_q     <= sx_a;
      w_conflict <= conflict;
      for (int unsigned k = 0; k < RP; k++) begin
        if (!run) begin
          r_d[k*WIDTH +: WIDTH] <= '0;
          r_pe[k]               <= 1'b0;
        end else if (rd_en[k]) begin
          r_d[k*WIDTH +: WIDTH] <= rd_val[k][WIDTH-1:0];
          r_pe[k]               <= par_bad(rd_val[k]);
        end else begin
          r_pe[k] <= 1'b0;
        end
      end
      scrub_bad_q  <= scrub_go & par_bad(scrub_val);
      scrub_addr_q <= scrub_ptr;
      if (scrub_go) scrub_ptr <= (scrub_ptr == LAST) ? '0 : scrub_ptr + 1'b1;
      if (scrub_bad_q && (!scrub_err_vld || scrub_err_clr)) begin
        scrub_err_vld  <= 1'b1;
        scrub_err_addr <= scrub_addr_q;
      end else if (scrub_err_clr) begin
        scrub_err_vld  <= 1'b0;
        scrub_err_addr <= '0;
      end
    end
  end
endmodule

// File: doc/xu_gpr_mp.md
# xu_gpr_mp

Parametrised multi-port GPR array with byte parity. It replaces the fixed 144-entry, 4-read/4-write GPR macro pair in the XU with a single configurable array. The array sits between the XU issue/operand-read stage and the writeback buses. It adds three things: a hardware clear-on-reset sequencer, write-port conflict detection, and a background parity scrubber that uses idle cycles of read port 0. It keeps the deferred third-source read path, which steals read port 0 for erativax-style operations.

## Interface
- WIDTH, 64: data bits per entry; must be a multiple of 8; stored entry = WIDTH + WIDTH/8 parity bits.
- DEPTH, 144: entries (GPR pool × threads); 2 ≤ DEPTH ≤ 2^AW.
- AW, 8: address width.
- RP, 4: read ports (≥1).
- WP, 4: write ports (≥1).

Ports:
- nclk in 1: the single clock; all state updates on rising edge.
- rst in 1: synchronous, active-high reset.
- r_e in RP: per-port read enable.
- r_a in RP*AW: read addresses; port k in bits [k*AW +: AW].
- r_d out RP*WIDTH: read data; port k in [k*WIDTH +: WIDTH].
- r_pe out RP: per-port parity error, aligned with r_d.
- sx_e in 1: deferred third-source read request.
- sx_a in AW: deferred read address.
- sx_sel in 1: qualifier in the steal cycle; steal happens only if 1.
- sx_steal out 1: port 0 was stolen this cycle.
- w_e in WP: write enables.
- w_a in WP*AW: write addresses.
- w_d in WP*(WIDTH+WIDTH/8): write data, writer-supplied parity in the upper WIDTH/8 bits of each slice.
- w_conflict out 1: two or more enabled write ports hit the same address last cycle.
- init_busy out 1: clear sequence in progress.
- scrub_en in 1: enable background scrub.
- scrub_err out 1: one-cycle pulse, scrub found a parity error.
- scrub_err_vld out 1: sticky error flag.
- scrub_err_addr out AW: address of the first unacknowledged scrub error.
- scrub_err_clr in 1: clears scrub_err_vld and scrub_err_addr.
- scrub_wrap out 1: pulse when the scrub pointer wraps.

## Operation
- **Reset values:**
  - r_d = 0, r_pe = 0, sx_steal = 0, w_conflict = 0.
  - scrub_err = 0, scrub_err_vld = 0, scrub_err_addr = 0, scrub_wrap = 0.
  - init_busy = 1.
- **Init FSM (INIT → RUN):**
  - While rst is high: the init pointer is held at 0.
  - After rst falls: one entry per cycle, address 0..DEPTH-1, is written with all-zero data and all-zero parity.
  - After entry DEPTH-1 is written: go to RUN and set init_busy = 0.
  - Asserting rst in any state returns the FSM to INIT with the pointer at 0.
  - During INIT:
    - All w_e are ignored.
    - All reads return 0 with r_pe = 0.
    - sx requests are discarded.
    - The scrubber is idle.
- **Writes:**
  - Ports are evaluated in parallel.
  - If several enabled ports target the same address, the highest-numbered port wins and w_conflict pulses the next cycle.
  - Addresses ≥ DEPTH are dropped silently.
- **Reads:**
  - The address and enable are registered; r_d[k] shows array[addr_q] from the cycle after the request.
  - A read issued in cycle N returns any write committed on the same edge (write-before-read).
  - When the registered enable is 0, r_d[k] holds its previous value.
  - Reads of addresses ≥ DEPTH return 0 with r_pe = 0.
  - r_pe[k] = registered enable & (XOR of each stored data byte ≠ its stored parity bit).
- **Deferred read:**
  - sx_e/sx_a are latched each cycle.
  - In the next cycle, if sx_e_q & sx_sel, port 0 uses sx_a_q in place of r_a[0], and the port is treated as enabled.
  - sx_steal pulses in that same cycle.
  - The simultaneous r_e[0] request is lost; the issuer must replay it.
  - r_pe[0] on the stolen read follows the normal rule.
- **Scrubber (RUN and scrub_en only):**
  - In any cycle where effective port 0 is idle (no r_e[0], no steal), the scrubber reads array[scrub_ptr] through port 0's array path.
  - Port-0 outputs (r_d, r_pe) are not disturbed.
  - The parity check is evaluated one cycle later.
  - The pointer increments after each issued scrub read and wraps from DEPTH-1 to 0; scrub_wrap pulses in the cycle of the wrap.
  - On error:
    - scrub_err pulses.
    - If scrub_err_vld = 0, scrub_err_addr is captured and scrub_err_vld is set.
    - Later errors pulse only; the address is not overwritten.
  - If scrub_err_clr coincides with a new error, the new error is captured.
  - Dropping scrub_en holds the pointer; re-enabling resumes from it.

## Timing
- Read latency: 1 cycle.
- Write: committed on the edge ending the write cycle.
- Init: DEPTH cycles from the first cycle with rst low; init_busy falls on the edge after entry DEPTH-1 is cleared.
- Steal: 1 cycle after sx_e.
- Scrub: error pulse 1 cycle after the scrub read; full sweep takes ≥ DEPTH idle cycles.
- w_conflict: 1 cycle after the colliding writes.

## Test plan
- **Reset/init:** rst for 3 cycles, then release.
  - init_busy stays high for exactly 144 cycles.
  - During that time, writing 0xFF.. to address 5 is ignored.
  - After that, a read of address 5 returns 0 with r_pe = 0.
- **Write-before-read and conflict:**
  - In the same cycle, write port 1 writes 0x1122334455667788 (good parity) to address 10 while read port 2 reads address 10; the next cycle r_d[2] shows the value.
  - Ports 0 and 3 write address 20 in the same cycle; port 3 data is stored and w_conflict = 1 the next cycle.
- **Parity error:** write address 7 with parity bit 0 flipped, then read it on port 1 → r_pe[1] = 1 and r_pe[0,2,3] = 0.
- **Steal:**
  - sx_e = 1, sx_a = 30 in cycle N.
  - In cycle N+1: sx_sel = 1, r_e[0] = 1, r_a[0] = 31, sx_steal = 1.
  - In cycle N+2: r_d[0] = array[30].
- **Scrub:**
  - Corrupt addresses 50 and 60, then set scrub_en with port 0 idle.
  - scrub_err pulses twice, and scrub_err_addr = 50 with vld = 1.
  - scrub_wrap pulses after 144 scrub reads.
  - After scrub_err_clr, the next sweep captures address 50 again.
- **Reset mid-scrub/init:** assert rst while the init pointer is at 70 → init restarts from 0, scrub_err_vld = 0, and init_busy stays high for a full 144 cycles.
